// File: rtl/icache_tag_ctrl.sv
// Two-way instruction-cache tag controller: lookup, LRU victim choice, line-fill request and tag write.
// Optional feature macro: ICACHE_TAG_PERF_CNT_EN adds perf_hits / perf_misses counters.
module icache_tag_ctrl #(
    parameter int TAG_W = 23,
    parameter int IDX_W = 6
) (
    input  logic                 clk0,
    input  logic                 rst_aL,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [31:0]          req_addr,
    output logic                 resp_valid,
    output logic                 resp_hit,
    output logic                 resp_way,
    output logic                 miss_valid,
    input  logic                 miss_ready,
    output logic [31:0]          miss_addr,
    input  logic                 fill_done,
    output logic                 sram_csb0,
    output logic                 sram_web0,
    output logic [1:0]           sram_wmask0,
    output logic [IDX_W-1:0]     sram_addr0,
    output logic [2*TAG_W+1:0]   sram_din0,
    input  logic [2*TAG_W+1:0]   sram_dout0
`ifdef ICACHE_TAG_PERF_CNT_EN
    ,
    output logic [31:0]          perf_hits,
    output logic [31:0]          perf_misses
`endif
);

    localparam int OFF_W = 32 - TAG_W - IDX_W;
    localparam int SETS  = 1 << IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_WAIT,
        FILL_WR
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [TAG_W-1:0]   r_tag;
    logic [IDX_W-1:0]   r_idx;
    logic               r_victim;
    logic [SETS-1:0]    r_lru;
    logic               r_resp_valid;
    logic               r_resp_hit;
    logic               r_resp_way;
    logic [31:0]        r_miss_addr;

    logic [TAG_W-1:0]   w_req_tag;
    logic [IDX_W-1:0]   w_req_idx;
    logic               w_unused_off;
    logic               w_way0_v;
    logic               w_way1_v;
    logic [TAG_W-1:0]   w_way0_tag;
    logic [TAG_W-1:0]   w_way1_tag;
    logic               w_hit0;
    logic               w_hit1;
    logic               w_hit;
    logic               w_hit_way;
    logic               w_victim;

    assign w_req_tag    = req_addr[31 -: TAG_W];
    assign w_req_idx    = req_addr[OFF_W +: IDX_W];
    assign w_unused_off = ^req_addr[OFF_W-1:0];

    // SRAM word layout: {way1_v, way1_tag, way0_v, way0_tag}
    assign w_way0_tag = sram_dout0[TAG_W-1:0];
    assign w_way0_v   = sram_dout0[TAG_W];
    assign w_way1_tag = sram_dout0[2*TAG_W:TAG_W+1];
    assign w_way1_v   = sram_dout0[2*TAG_W+1];

    assign w_hit0    = w_way0_v && (w_way0_tag == r_tag);
    assign w_hit1    = w_way1_v && (w_way1_tag == r_tag);
    assign w_hit     = w_hit0 || w_hit1;
    assign w_hit_way = !w_hit0;

    // Fill invalid ways first; only a full set falls back to the LRU bit.
    assign w_victim  = !w_way0_v ? 1'b0 :
                       !w_way1_v ? 1'b1 : r_lru[r_idx];

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (req_valid)  w_next = LOOKUP;
            LOOKUP:    w_next = w_hit ? IDLE : MISS_REQ;
            MISS_REQ:  if (miss_ready) w_next = MISS_WAIT;
            MISS_WAIT: if (fill_done)  w_next = FILL_WR;
            FILL_WR:   w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_comb begin
        sram_csb0   = 1'b1;
        sram_web0   = 1'b1;
        sram_wmask0 = 2'b00;
        sram_addr0  = '0;
        sram_din0   = '0;
        if (r_state == IDLE && req_valid) begin
            sram_csb0  = 1'b0;
            sram_addr0 = w_req_idx;
        end else if (r_state == FILL_WR) begin
            sram_csb0   = 1'b0;
            sram_web0   = 1'b0;
            sram_addr0  = r_idx;
            sram_din0   = {1'b1, r_tag, 1'b1, r_tag};
            sram_wmask0 = r_victim ? 2'b10 : 2'b01;
        end
        // Strobes are gated so no access can leak out while reset is held.
        if (!rst_aL) begin
            sram_csb0   = 1'b1;
            sram_web0   = 1'b1;
            sram_wmask0 = 2'b00;
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign miss_valid = (r_state == MISS_REQ);
    assign miss_addr  = r_miss_addr;
    assign resp_valid = r_resp_valid;
    assign resp_hit   = r_resp_hit;
    assign resp_way   = r_resp_way;

    always_ff @(posedge clk0 or negedge rst_aL) begin
        if (!rst_aL) begin
            r_state      <= IDLE;
            r_tag        <= '0;
            r_idx        <= '0;
            r_victim     <= 1'b0;
            r_lru        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_way   <= 1'b0;
            r_miss_addr  <= '0;
        end else begin
            r_state      <= w_next;
            r_resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_tag <= w_req_tag;
                        r_idx <= w_req_idx;
                    end
                end
                LOOKUP: begin
                    if (w_hit) begin
                        r_resp_valid <= 1'b1;
                        r_resp_hit   <= 1'b1;
                        r_resp_way   <= w_hit_way;
                        r_lru[r_idx] <= !w_hit_way;
                    end else begin
                        r_victim    <= w_victim;
                        r_miss_addr <= {r_tag, r_idx, {OFF_W{1'b0}}};
                    end
                end
                FILL_WR: begin
                    r_resp_valid <= 1'b1;
                    r_resp_hit   <= 1'b0;
                    r_resp_way   <= r_victim;
                    r_lru[r_idx] <= !r_victim;
                end
                default: ;
            endcase
        end
    end

`ifdef ICACHE_TAG_PERF_CNT_EN
    logic [31:0] r_perf_hits;
    logic [31:0] r_perf_misses;

    always_ff @(posedge clk0 or negedge rst_aL) begin
        if (!rst_aL) begin
            r_perf_hits   <= '0;
            r_perf_misses <= '0;
        end else if (r_state == LOOKUP) begin
            if (w_hit) r_perf_hits   <= r_perf_hits + 32'd1;
            else       r_perf_misses <= r_perf_misses + 32'd1;
        end
    end

    assign perf_hits   = r_perf_hits;
    assign perf_misses = r_perf_misses;
`endif

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// Scoreboard bench for icache_tag_ctrl with a behavioural tag SRAM (registered read, masked write).
module tb_icache_tag_ctrl;

    logic        clk0 = 1'b0;
    logic        rst_aL;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid, resp_hit, resp_way;
    logic        miss_valid;
    logic        miss_ready;
    logic [31:0] miss_addr;
    logic        fill_done;
    logic        sram_csb0, sram_web0;
    logic [1:0]  sram_wmask0;
    logic [5:0]  sram_addr0;
    logic [47:0] sram_din0;
    logic [47:0] sram_dout0;
`ifdef ICACHE_TAG_PERF_CNT_EN
    logic [31:0] perf_hits, perf_misses;
`endif

    icache_tag_ctrl #(.TAG_W(23), .IDX_W(6)) dut (
        .clk0(clk0), .rst_aL(rst_aL),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
        .fill_done(fill_done),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
`ifdef ICACHE_TAG_PERF_CNT_EN
        , .perf_hits(perf_hits), .perf_misses(perf_misses)
`endif
    );

    always #5 clk0 = ~clk0;

    int cyc = 0;
    always @(posedge clk0) cyc <= cyc + 1;

    logic [47:0] mem [0:63];
    always @(posedge clk0) begin
        if (!sram_csb0) begin
            if (sram_web0) sram_dout0 <= mem[sram_addr0];
            else begin
                if (sram_wmask0[0]) mem[sram_addr0][23:0]  <= sram_din0[23:0];
                if (sram_wmask0[1]) mem[sram_addr0][47:24] <= sram_din0[47:24];
            end
        end
    end

    typedef struct { logic hit; logic way; int cyc; } resp_t;
    typedef struct { logic [5:0] idx; logic [1:0] mask; logic [47:0] din; } wr_t;
    resp_t       q_resp[$];
    wr_t         q_wr[$];
    logic [31:0] q_miss[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: got none/unexpected expected event (t=%0t)", name, $time);
    endtask

    // Monitor: every DUT output event pops its matching expectation.
    always @(negedge clk0) begin
        if (rst_aL) begin
            if (resp_valid) begin
                if (q_resp.size() == 0) fail("resp_unexpected");
                else begin
                    resp_t e;
                    e = q_resp.pop_front();
                    check("resp_hit", resp_hit, e.hit);
                    check("resp_way", resp_way, e.way);
                    if (e.cyc >= 0) check("resp_latency", cyc, e.cyc);
                end
            end
            if (!sram_csb0 && !sram_web0) begin
                if (q_wr.size() == 0) fail("sram_write_unexpected");
                else begin
                    wr_t w;
                    w = q_wr.pop_front();
                    check("wr_addr", sram_addr0, w.idx);
                    check("wr_mask", sram_wmask0, w.mask);
                    check("wr_din", sram_din0, w.din);
                end
            end
            if (miss_valid && miss_ready) begin
                if (q_miss.size() == 0) fail("miss_unexpected");
                else check("miss_addr", miss_addr, q_miss.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, output int acc);
        req_valid = 1'b1;
        req_addr  = a;
        acc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk0);
            if (req_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) fail("accept_timeout");
        tick();
        req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((q_resp.size() != 0 || q_wr.size() != 0 || q_miss.size() != 0) && k < 40) begin
            tick();
            k++;
        end
        if (k >= 40) fail(name);
    endtask

    task automatic lookup_hit(input logic [31:0] a, input logic way);
        int acc;
        resp_t e;
        issue(a, acc);
        e.hit = 1'b1; e.way = way; e.cyc = acc + 2;
        q_resp.push_back(e);
        drain("hit_timeout");
    endtask

    task automatic wait_miss_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk0);
            if (miss_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail("miss_valid_timeout");
    endtask

    task automatic lookup_miss(input logic [31:0] a, input logic victim,
                               input logic [5:0] idx, input logic [47:0] din);
        int acc;
        bit ok;
        resp_t e;
        wr_t w;
        issue(a, acc);
        e.hit = 1'b0; e.way = victim; e.cyc = -1;
        q_resp.push_back(e);
        w.idx = idx; w.mask = victim ? 2'b10 : 2'b01; w.din = din;
        q_wr.push_back(w);
        q_miss.push_back(a);
        wait_miss_valid(ok);
        tick();
        @(negedge clk0);
        check("miss_hold_valid", miss_valid, 1'b1);
        check("miss_hold_addr", miss_addr, a);
        tick(); miss_ready = 1'b1;
        tick(); miss_ready = 1'b0;
        tick(); fill_done = 1'b1;
        tick(); fill_done = 1'b0;
        drain("miss_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1);
    end

    initial begin
        int    acc;
        bit    ok;
        resp_t e;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        sram_dout0 = '0;
        rst_aL = 1'b0; req_valid = 1'b0; req_addr = '0;
        miss_ready = 1'b0; fill_done = 1'b0;
        #3;
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_miss_valid", miss_valid, 1'b0);
        check("rst_miss_addr", miss_addr, 32'h0);
        check("rst_csb", sram_csb0, 1'b1);
        check("rst_web", sram_web0, 1'b1);
        check("rst_wmask", sram_wmask0, 2'b00);
        check("rst_din", sram_din0, 48'h0);
        repeat (3) tick();
        rst_aL = 1'b1;
        @(negedge clk0);
        check("ready_first_cycle", req_ready, 1'b1);
        tick();

        // Cold miss, hit, second way, LRU eviction of way0, then 0x1208 misses again into way1
        lookup_miss(32'h0000_1208, 1'b0, 6'd1, 48'h800009_800009);
        lookup_hit (32'h0000_1208, 1'b0);
        lookup_miss(32'h0000_1408, 1'b1, 6'd1, 48'h80000A_80000A);
        lookup_miss(32'h0000_1608, 1'b0, 6'd1, 48'h80000B_80000B);
        lookup_miss(32'h0000_1208, 1'b1, 6'd1, 48'h800009_800009);
        lookup_hit (32'h0000_1608, 1'b0);

        // Reset while waiting for the fill: transaction must vanish
        issue(32'h0000_2010, acc);
        q_miss.push_back(32'h0000_2010);
        wait_miss_valid(ok);
        tick(); miss_ready = 1'b1;
        tick(); miss_ready = 1'b0;
        tick();
        rst_aL = 1'b0;
        #1;
        check("mw_rst_miss_valid", miss_valid, 1'b0);
        check("mw_rst_miss_addr", miss_addr, 32'h0);
        check("mw_rst_csb", sram_csb0, 1'b1);
        check("mw_rst_resp_valid", resp_valid, 1'b0);
        tick(); tick();
        rst_aL = 1'b1;
        @(negedge clk0);
        check("mw_ready_first_cycle", req_ready, 1'b1);
        tick(); fill_done = 1'b1;
        tick(); fill_done = 1'b0;
        repeat (5) tick();
        @(negedge clk0);
        check("mw_still_idle", req_ready, 1'b1);
        check("mw_no_pending_miss", q_miss.size(), 0);
        tick();

        // Back-to-back: req_valid held through the hit response
        req_valid = 1'b1;
        req_addr  = 32'h0000_1208;
        acc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk0);
            if (req_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) fail("b2b_accept_timeout");
        e.hit = 1'b1; e.way = 1'b1; e.cyc = acc + 2;
        q_resp.push_back(e);
        tick();
        req_addr = 32'h0000_1608;
        tick();
        @(negedge clk0);
        check("b2b_resp_valid", resp_valid, 1'b1);
        check("b2b_ready", req_ready, 1'b1);
        e.hit = 1'b1; e.way = 1'b0; e.cyc = cyc + 2;
        q_resp.push_back(e);
        tick();
        req_valid = 1'b0;
        drain("b2b_timeout");

        lookup_miss(32'h0000_2010, 1'b0, 6'd2, 48'h800010_800010);
        lookup_miss(32'h0000_0018, 1'b0, 6'd3, 48'h800000_800000);
        lookup_miss(32'h0000_1408, 1'b1, 6'd1, 48'h80000A_80000A);
`ifdef ICACHE_TAG_PERF_CNT_EN
        @(negedge clk0);
        check("perf_hits", perf_hits, 32'd2);
        check("perf_misses", perf_misses, 32'd3);
        tick();
`endif
        lookup_hit(32'h0000_1408, 1'b1);

        repeat (3) tick();
        check("end_resp_q", q_resp.size(), 0);
        check("end_wr_q", q_wr.size(), 0);
        check("end_miss_q", q_miss.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
